// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Purpose : Shared types and helpers for the restoring divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; runs 0..w-1.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // Low w bits set, returned in a 32-bit container.
  function automatic logic [31:0] all_ones(input int w);
    logic [31:0] ones;
    ones = '1;
    return ones >> (32 - w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ripple_sub.sv
// ============================================================================
// Module  : ripple_sub
// Purpose : N-bit ripple subtractor (a - b) from full adder/subtractor cells.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_sub #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-2:0] o_diff,
  output logic         o_sign
);

  localparam logic c_mode = 1'b1;

  logic [N-1:0] w_bx;
  logic [N-1:0] w_c;
  logic [N-1:0] w_s;

  assign w_c[0] = c_mode;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign w_bx[i] = i_b[i] ^ c_mode;
    assign w_s[i]  = i_a[i] ^ w_bx[i] ^ w_c[i];
    if (i < N - 1) begin : g_carry
      assign w_c[i+1] = (i_a[i] & w_bx[i]) | (w_c[i] & (i_a[i] ^ w_bx[i]));
    end
  end

  assign o_diff = w_s[N-2:0];
  assign o_sign = w_s[N-1];

endmodule

`default_nettype wire

// File: rtl/restoring_divider.sv
// ============================================================================
// Module  : restoring_divider
// Purpose : Multi-cycle unsigned restoring divider, one quotient bit per clock.
//           Optional macro DIV_ZERO_CHECK_EN short-cuts a zero divisor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int            CW     = cnt_width(WIDTH);
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  // R never exceeds the divisor after a restore, so its top bit is always 0
  // and only the low WIDTH bits are stored; the shift widens it to WIDTH+1.
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dreg;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_rsh;
  logic [WIDTH-1:0] w_t;
  logic             w_sign;

  assign w_rsh = {r_rem, r_q[WIDTH-1]};

  ripple_sub #(
    .N (WIDTH + 1)
  ) u_sub (
    .i_a    (w_rsh),
    .i_b    ({1'b0, r_dreg}),
    .o_diff (w_t),
    .o_sign (w_sign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
`ifdef DIV_ZERO_CHECK_EN
          w_next = (divisor == '0) ? DONE : RUN;
`else
          w_next = RUN;
`endif
        end
      end
      RUN:     if (r_cnt == c_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef DIV_ZERO_CHECK_EN
  localparam logic [31:0] c_ones32 = all_ones(WIDTH);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_q       <= '0;
      r_dreg    <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      busy <= (r_state == RUN);
      done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_rem  <= '0;
            r_q    <= dividend;
            r_dreg <= divisor;
            r_cnt  <= '0;
`ifdef DIV_ZERO_CHECK_EN
            // Pre-load the known answer so DONE publishes it uniformly.
            if (divisor == '0) begin
              r_rem <= dividend;
              r_q   <= c_ones32[WIDTH-1:0];
            end
`endif
          end
        end
        RUN: begin
          r_rem <= w_sign ? w_rsh[WIDTH-1:0] : w_t;
          r_q   <= {r_q[WIDTH-2:0], ~w_sign};
          r_cnt <= r_cnt + 1'b1;
        end
        DONE: begin
          quotient  <= r_q;
          remainder <= r_rem;
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_zero <= 1'b0;
    end else if (r_state == IDLE && start) begin
      div_zero <= 1'b0;
    end else if (r_state == DONE) begin
      div_zero <= (r_dreg == '0);
    end
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider.sv
// ============================================================================
// Module  : tb_restoring_divider
// Purpose : Directed + random self-checking bench for restoring_divider.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_restoring_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int checks   = 0;
  int failures = 0;

  restoring_divider #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DIV_ZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; zero divisor yields all ones / dividend.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int dz, output int lat);
    if (b == 0) begin
      q   = (1 << W) - 1;
      r   = a;
      dz  = ZCHK ? 1 : 0;
      lat = ZCHK ? 1 : W + 1;
    end else begin
      q   = a / b;
      r   = a % b;
      dz  = 0;
      lat = W + 1;
    end
  endfunction

  task automatic run_op(input int a, input int b, input int glitch_at);
    int eq, er, ez, elat, seen;
    bit fast;
    model(a, b, eq, er, ez, elat);
    fast = (elat == 1);
    @(negedge clk);
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    @(posedge clk); #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    seen = 0;
    for (int n = 1; n <= W + 4 && seen == 0; n++) begin
      @(posedge clk); #1;
      if (done) seen = n;
      else if (fast) check("busy_zero_path", 32'(busy), 0);
      else if (n <= W) check("busy_run", 32'(busy), 1);
      if (n == glitch_at) begin
        start = 1'b1; dividend = W'(13); divisor = W'(2);
      end else if (n == glitch_at + 1) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency", 32'(seen), 32'(elat));
    if (seen != 0) begin
      check("quotient", 32'(quotient), 32'(eq));
      check("remainder", 32'(remainder), 32'(er));
      check("div_zero", 32'(div_zero), 32'(ez));
      check("busy_at_done", 32'(busy), 0);
      @(posedge clk); #1;
      check("done_width", 32'(done), 0);
      check("quotient_held", 32'(quotient), 32'(eq));
    end
  endtask

  initial begin
    int qa[3];
    int qb[3];
    int eq, er, ez, elat;
    start = 1'b0; dividend = '0; divisor = '0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_quotient", 32'(quotient), 0);
    check("rst_remainder", 32'(remainder), 0);
    check("rst_div_zero", 32'(div_zero), 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(100, 7, 0);
    run_op(7, 100, 0);
    run_op(255, 1, 0);
    run_op(50, 0, 0);
    run_op(200, 9, 2);

    // Reset during RUN cycle 4 of 181/5.
    @(negedge clk);
    start = 1'b1; dividend = W'(181); divisor = W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrun_busy", 32'(busy), 0);
    check("midrun_done", 32'(done), 0);
    check("midrun_quotient", 32'(quotient), 0);
    check("midrun_remainder", 32'(remainder), 0);
    check("midrun_div_zero", 32'(div_zero), 0);
    @(negedge clk); rst_n = 1'b1;
    run_op(181, 5, 0);

    // Back-to-back with start held high: accepts every W+2 cycles.
    for (int i = 0; i < 3; i++) begin
      qa[i] = $urandom_range(0, (1 << W) - 1);
      qb[i] = $urandom_range(1, (1 << W) - 1);
    end
    @(negedge clk);
    start = 1'b1; dividend = W'(qa[0]); divisor = W'(qb[0]);
    @(posedge clk); #1;
    dividend = W'(qa[1]); divisor = W'(qb[1]);
    for (int n = 1; n <= 3 * (W + 2); n++) begin
      @(posedge clk); #1;
      if (n % (W + 2) == W + 1) begin
        model(qa[n / (W + 2)], qb[n / (W + 2)], eq, er, ez, elat);
        check("b2b_done", 32'(done), 1);
        check("b2b_quotient", 32'(quotient), 32'(eq));
        check("b2b_remainder", 32'(remainder), 32'(er));
      end else begin
        check("b2b_done_low", 32'(done), 0);
      end
      if (n == W + 2) begin
        dividend = W'(qa[2]); divisor = W'(qb[2]);
      end
      if (n == 2 * (W + 2) + 1) start = 1'b0;
    end

    // Random operands, occasionally a zero divisor.
    for (int i = 0; i < 16; i++) begin
      int a, b;
      a = $urandom_range(0, (1 << W) - 1);
      b = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, (1 << W) - 1);
      run_op(a, b, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
